ex_muldiv: RTL
==============

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is required to work.
REQ-002 clk_i  input  1  clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 valid_i  input  1  ID/EX register holds a live instruction.
REQ-005 is_muldiv_i  input  1  instruction is RV32M (opcode 0110011, funct7 0000001).
REQ-006 funct3_i  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1_i, rs2_i  input  XLEN each  operands, taken from ID/EX Rd1/Rd2 after forwarding.
REQ-008 rd_i  input  5  destination register index.
REQ-009 flush_i  input  1  pipeline flush; aborts the operation in progress.
REQ-010 stall_o  output  1  holds the ID/EX register and all earlier stages (drives the ID/EX data-stall input).
REQ-011 done_o  output  1  one-cycle pulse; result_o/rd_o valid.
REQ-012 result_o  output  XLEN  M-op result.
REQ-013 rd_o  output  5  destination index of result_o.
REQ-014 busy_o  output  1  state is not IDLE.

Function
REQ-015 FSM states: IDLE, BUSY, DONE.
REQ-016 Start condition: IDLE and valid_i and is_muldiv_i and not flush_i; operands, funct3_i and rd_i are latched on that edge.
REQ-017 Transitions: IDLE->BUSY on start; IDLE->DONE on start with a short-circuit case (REQ-022, REQ-023, or REQ-027 when enabled); BUSY->DONE when the iteration counter reaches 0; DONE->IDLE unconditionally.
REQ-018 stall_o = (IDLE and start condition) or BUSY, combinational; stall_o is 0 in DONE so the instruction leaves ID/EX at the end of DONE.
REQ-019 A start is accepted only in IDLE; valid_i/is_muldiv_i in DONE are ignored, so each instruction executes exactly once.
REQ-020 Iterative path: 5-bit counter loaded with 31 on start, decremented each BUSY cycle; one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; 32 BUSY cycles. Start at cycle T gives done_o at T+33 and stall_o high for T..T+32.
REQ-021 Signed ops iterate on magnitudes, with the sign applied in DONE. Product sign = sign(a) xor sign(b). Quotient sign = sign(a) xor sign(b). Remainder sign = sign(a). MULHSU treats rs1 as signed and rs2 as unsigned. MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
REQ-022 Divide by zero short-circuit: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
REQ-023 Signed overflow short-circuit (rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
REQ-024 result_o and rd_o are registered, update only on entry to DONE, and hold their values until the next DONE.
REQ-025 flush_i high in any state: next state IDLE; done_o stays 0 that cycle and the next; stall_o is 0 in the flush cycle; result_o is unchanged.

Reset
REQ-026 While rst_i is low (asynchronous): state=IDLE, counter=0, result_o=0, rd_o=0, done_o=0, busy_o=0, stall_o=0; an operation in progress is discarded with no done_o after release.

Configuration
REQ-027 Macro MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle combinational 33x33 signed multiplier and go IDLE->DONE (done_o at T+1, stall_o high only at T). Macro undefined: all multiplies use the 32-cycle iterative path of REQ-020. Divide behaviour is identical in both builds.

Verification
REQ-028 MUL rs1=7, rs2=0xFFFFFFFD, start at T -> stall_o high T..T+32, done_o at T+33, result_o=0xFFFFFFEB (with MULDIV_FAST_MUL_EN: done_o at T+1).
REQ-029 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-030 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1; REM with the same operands -> 0; DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-031 DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; both with done_o at T+1.
REQ-032 DIVU 100/7 with flush_i pulsed at BUSY cycle 10 -> IDLE next cycle, no done_o, stall_o low, result_o unchanged; re-issued DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 rst_i low mid-BUSY -> all outputs 0 immediately without a clock edge; after release, no done_o until a new start.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: ID/EX-side handshake and result bus of the RV32M execute unit
interface ex_muldiv_if #(parameter int XLEN = 32);
   logic            valid_i;
   logic            is_muldiv_i;
   logic [2:0]      funct3_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic [4:0]      rd_i;
   logic            flush_i;
   logic            stall_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;
   logic [4:0]      rd_o;
   logic            busy_o;

   modport master (
      output valid_i, is_muldiv_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i,
      input  stall_o, done_o, result_o, rd_o, busy_o
   );

   modport slave (
      input  valid_i, is_muldiv_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i,
      output stall_o, done_o, result_o, rd_o, busy_o
   );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit; define MULDIV_FAST_MUL_EN for single-cycle multiplies
module ex_muldiv #(parameter int XLEN = 32) (
   input logic        clk_i,
   input logic        rst_i,
   ex_muldiv_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   logic [4:0]        cnt;
   logic [4:0]        rd_q;
   logic [4:0]        rd_r;
   logic [2:0]        op;
   logic              neg_q;
   logic              neg_r;
   logic              done_q;
   logic [XLEN-1:0]   hi;
   logic [XLEN-1:0]   lo;
   logic [XLEN-1:0]   b;
   logic [XLEN-1:0]   res;
   logic              start;
   logic              sa;
   logic              sb;
   logic              neg_a;
   logic              neg_b;
   logic              dz;
   logic              ovf;
   logic              fast;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN-1:0]   short_res;
   logic [XLEN-1:0]   fast_res;
   logic [XLEN-1:0]   nhi;
   logic [XLEN-1:0]   nlo;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   iter_res;
   logic [XLEN:0]     sum;
   logic [XLEN:0]     t;
   logic [XLEN:0]     d;
   logic [2*XLEN-1:0] prod;

   // decode a starting op: operand signedness, magnitudes and short-circuit cases
   always_comb begin
      start     = state == IDLE && bus.valid_i && bus.is_muldiv_i && !bus.flush_i;
      sa        = bus.funct3_i[2] ? !bus.funct3_i[0] : bus.funct3_i[1:0] != 2'b11;
      sb        = bus.funct3_i[2] ? !bus.funct3_i[0] : bus.funct3_i[1:0] == 2'b01;
      neg_a     = sa && bus.rs1_i[XLEN-1];
      neg_b     = sb && bus.rs2_i[XLEN-1];
      mag_a     = neg_a ? -bus.rs1_i : bus.rs1_i;
      mag_b     = neg_b ? -bus.rs2_i : bus.rs2_i;
      dz        = bus.funct3_i[2] && bus.rs2_i == '0;
      ovf       = bus.funct3_i[2] && !bus.funct3_i[0] && bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2_i == '1;
      short_res = dz ? (bus.funct3_i[1] ? bus.rs1_i : '1) : (bus.funct3_i[1] ? '0 : bus.rs1_i);
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [XLEN:0]     fa;
   logic [XLEN:0]     fb;
   logic [2*XLEN-1:0] fp;

   // single-cycle 33x33 signed multiply; unsigned operands get a zero sign bit
   always_comb begin
      fa       = {sa && bus.rs1_i[XLEN-1], bus.rs1_i};
      fb       = {sb && bus.rs2_i[XLEN-1], bus.rs2_i};
      fp       = {{(XLEN-1){fa[XLEN]}}, fa} * {{(XLEN-1){fb[XLEN]}}, fb};
      fast     = !bus.funct3_i[2];
      fast_res = bus.funct3_i[1:0] == 2'b00 ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
   end
`else
   assign fast     = 1'b0;
   assign fast_res = '0;
`endif

   // one shift-add or restoring shift-subtract step on {hi,lo}, plus the signed final result
   always_comb begin
      sum      = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
      t        = {hi, lo[XLEN-1]};
      d        = t - {1'b0, b};
      nhi      = op[2] ? (d[XLEN] ? t[XLEN-1:0] : d[XLEN-1:0]) : sum[XLEN:1];
      nlo      = op[2] ? {lo[XLEN-2:0], !d[XLEN]} : {sum[0], lo[XLEN-1:1]};
      prod     = neg_q ? -{nhi, nlo} : {nhi, nlo};
      quo      = neg_q ? -nlo : nlo;
      rem      = neg_r ? -nhi : nhi;
      iter_res = op[2] ? (op[1] ? rem : quo) : (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
   end

   assign bus.stall_o  = rst_i && !bus.flush_i && (start || state == BUSY);
   assign bus.done_o   = done_q && !bus.flush_i;
   assign bus.busy_o   = state != IDLE;
   assign bus.result_o = res;
   assign bus.rd_o     = rd_r;

   // FSM: latch on start, iterate 32 steps in BUSY, publish result on entry to DONE
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         op     <= '0;
         rd_q   <= '0;
         rd_r   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         done_q <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         b      <= '0;
         res    <= '0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush_i) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     op    <= bus.funct3_i;
                     rd_q  <= bus.rd_i;
                     neg_q <= neg_a ^ neg_b;
                     neg_r <= neg_a;
                     b     <= mag_b;
                     hi    <= '0;
                     lo    <= mag_a;
                     cnt   <= 5'd31;
                     if (dz || ovf || fast) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        res    <= (dz || ovf) ? short_res : fast_res;
                        rd_r   <= bus.rd_i;
                     end else begin
                        state <= BUSY;
                     end
                  end
               end
               BUSY: begin
                  hi <= nhi;
                  lo <= nlo;
                  if (cnt == 5'd0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     res    <= iter_res;
                     rd_r   <= rd_q;
                  end else begin
                     cnt <= cnt - 5'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
